// File: rtl/mem_lsu.sv
// Load/store unit: accepts one ex-stage operation at a time, runs a single bus transfer
// for aligned loads/stores, and returns a registered one-cycle write-back/exception result.
module mem_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_load,
    input  logic                in_is_store,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [4:0]          in_rd_addr,
    input  logic                in_rd_wr_en,
    input  logic [DATA_W-1:0]   in_rd_data,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic                bus_err,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                out_valid,
    output logic                out_rd_wr_en,
    output logic [4:0]          out_rd_addr,
    output logic [DATA_W-1:0]   out_rd_data,
    output logic                out_exc,
    output logic [1:0]          out_exc_code
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [4:0]          rd_addr_q, rd_addr_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [BE_W-1:0]     bus_be_q, bus_be_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic                out_wr_q, out_wr_d;
    logic [4:0]          out_rd_addr_q, out_rd_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_exc_q, out_exc_d;
    logic [1:0]          out_code_q, out_code_d;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3[2] || (f3 == 3'b011 && DATA_W != 64);
        return (f3 == 3'b111) || ((f3 == 3'b011 || f3 == 3'b110) && DATA_W != 64);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    function automatic logic [BE_W-1:0] be_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [BE_W-1:0] base;
        case (size)
            2'd0:    base = BE_W'(1);
            2'd1:    base = BE_W'(3);
            2'd2:    base = BE_W'(15);
            default: base = '1;
        endcase
        return base << off;
    endfunction

    // Lane shift first, then sign/zero extension selected by funct3.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] rdata,
                                                   input logic [OFF_W-1:0] off,
                                                   input logic [2:0] f3);
        logic [DATA_W-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return DATA_W'($signed(sh[7:0]));
            3'b001:  return DATA_W'($signed(sh[15:0]));
            3'b010:  return DATA_W'($signed(sh[31:0]));
            3'b100:  return DATA_W'(sh[7:0]);
            3'b101:  return DATA_W'(sh[15:0]);
            3'b110:  return DATA_W'(sh[31:0]);
            default: return sh;
        endcase
    endfunction

    logic in_mem, bad_op;
    assign in_mem = in_is_load || in_is_store;
    assign bad_op = f3_illegal(in_is_store, in_funct3) ||
                    misaligned(in_funct3[1:0], in_addr[2:0]);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        is_store_d    = is_store_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        rd_addr_d     = rd_addr_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        out_valid_d   = 1'b0;
        out_wr_d      = 1'b0;
        out_exc_d     = 1'b0;
        out_code_d    = 2'b00;
        out_rd_addr_d = out_rd_addr_q;
        out_data_d    = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    is_store_d  = in_is_store;
                    funct3_d    = in_funct3;
                    off_d       = in_addr[OFF_W-1:0];
                    rd_addr_d   = in_rd_addr;
                    bus_we_d    = in_is_store;
                    bus_addr_d  = {in_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    bus_be_d    = in_is_store ? be_mask(in_funct3[1:0], in_addr[OFF_W-1:0]) : '0;
                    bus_wdata_d = in_is_store ? (in_wdata << {in_addr[OFF_W-1:0], 3'b000}) : '0;
                    cnt_d       = 8'd0;
                    if (!in_mem) begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_rd_addr_d = in_rd_addr;
                        out_data_d    = in_rd_data;
                        out_wr_d      = in_rd_wr_en && (in_rd_addr != 5'd0);
                    end else if (bad_op) begin
                        state_d       = DONE;
                        out_valid_d   = 1'b1;
                        out_rd_addr_d = in_rd_addr;
                        out_exc_d     = 1'b1;
                        out_code_d    = 2'b01;
                    end else begin
                        state_d = BUS;
                    end
                end
            end
            BUS: begin
                // An ack in the final allowed cycle wins over the timeout.
                if (bus_ack) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_rd_addr_d = rd_addr_q;
                    if (bus_err) begin
                        out_exc_d  = 1'b1;
                        out_code_d = 2'b10;
                    end else if (!is_store_q) begin
                        out_data_d = load_ext(bus_rdata, off_q, funct3_q);
                        out_wr_d   = (rd_addr_q != 5'd0);
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d       = DONE;
                    out_valid_d   = 1'b1;
                    out_rd_addr_d = rd_addr_q;
                    out_exc_d     = 1'b1;
                    out_code_d    = 2'b11;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_store_q    <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            rd_addr_q     <= '0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            out_valid_q   <= 1'b0;
            out_wr_q      <= 1'b0;
            out_rd_addr_q <= '0;
            out_data_q    <= '0;
            out_exc_q     <= 1'b0;
            out_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            is_store_q    <= is_store_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            rd_addr_q     <= rd_addr_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            out_valid_q   <= out_valid_d;
            out_wr_q      <= out_wr_d;
            out_rd_addr_q <= out_rd_addr_d;
            out_data_q    <= out_data_d;
            out_exc_q     <= out_exc_d;
            out_code_q    <= out_code_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign bus_req      = (state_q == BUS);
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign out_valid    = out_valid_q;
    assign out_rd_wr_en = out_wr_q;
    assign out_rd_addr  = out_rd_addr_q;
    assign out_rd_data  = out_data_q;
    assign out_exc      = out_exc_q;
    assign out_exc_code = out_code_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (DATA_W=32, TIMEOUT=4) with a reactive bus responder.
module tb_mem_lsu;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]        in_funct3;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata, in_rd_data;
    logic [4:0]        in_rd_addr;
    logic              in_rd_wr_en;
    logic              bus_req, bus_we, bus_ack, bus_err;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;
    logic              out_valid, out_rd_wr_en, out_exc;
    logic [4:0]        out_rd_addr;
    logic [DATA_W-1:0] out_rd_data;
    logic [1:0]        out_exc_code;

    mem_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rd_addr(in_rd_addr),
        .in_rd_wr_en(in_rd_wr_en), .in_rd_data(in_rd_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_rd_wr_en(out_rd_wr_en), .out_rd_addr(out_rd_addr),
        .out_rd_data(out_rd_data), .out_exc(out_exc), .out_exc_code(out_exc_code)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    int          r_lat, r_nreq;
    logic        r_we, r_stable, r_wren, r_exc;
    logic [31:0] r_addr, r_wdata, r_data;
    logic [3:0]  r_be;
    logic [1:0]  r_code;
    logic [4:0]  r_rd;

    // Presents one operation, answers the bus in its ack_at-th request cycle
    // (0 = never), and records latency counted from the presentation cycle.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic rdwe, input logic [31:0] rdd,
                          input int ack_at, input logic err, input logic [31:0] rdata);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; in_rd_addr = rd; in_rd_wr_en = rdwe; in_rd_data = rdd;
        cyc = 1; r_lat = 0; r_nreq = 0; r_stable = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && r_lat == 0; k++) begin
            cyc++;
            if (out_valid) begin
                r_lat = cyc; r_data = out_rd_data; r_wren = out_rd_wr_en;
                r_exc = out_exc; r_code = out_exc_code; r_rd = out_rd_addr;
            end else if (bus_req) begin
                r_nreq++;
                if (r_nreq == 1) begin
                    r_addr = bus_addr; r_we = bus_we; r_be = bus_be; r_wdata = bus_wdata;
                end else if (r_addr !== bus_addr || r_we !== bus_we || r_be !== bus_be ||
                             r_wdata !== bus_wdata) begin
                    r_stable = 1'b0;
                end
                bus_ack = (r_nreq == ack_at); bus_err = err; bus_rdata = rdata;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_err = 1'b0;
        end
        chk("post_valid_low", out_valid, 1'b0);
        chk("post_ready", in_ready, 1'b1);
        chk("post_data_hold", out_rd_data, r_data);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
        in_addr = '0; in_wdata = '0; in_rd_addr = '0; in_rd_wr_en = 1'b0; in_rd_data = '0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_rd_data, 32'h0);
        chk("rst_bus_be", bus_be, 4'h0);
        @(negedge clk); rst = 1'b0;

        // LB sign-extended, ack in 2nd bus cycle
        run_op(1, 0, 3'b000, 32'h1003, 0, 5'd5, 1, 0, 2, 0, 32'h80FF_FFFF);
        chk("lb_lat", r_lat, 4);
        chk("lb_nreq", r_nreq, 2);
        chk("lb_addr", r_addr, 32'h1000);
        chk("lb_we_be", {r_we, r_be}, 5'b0_0000);
        chk("lb_stable", r_stable, 1'b1);
        chk("lb_data", r_data, 32'hFFFF_FF80);
        chk("lb_wren_rd", {r_wren, r_exc, r_rd}, {1'b1, 1'b0, 5'd5});

        // SH lane 2
        run_op(0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd3, 1, 0, 1, 0, 0);
        chk("sh_lat", r_lat, 3);
        chk("sh_addr", r_addr, 32'h2000);
        chk("sh_be", {r_we, r_be}, 5'b1_1100);
        chk("sh_wdata", r_wdata, 32'hABCD_0000);
        chk("sh_wren_exc", {r_wren, r_exc}, 2'b00);

        // misaligned LW
        run_op(1, 0, 3'b010, 32'h0006, 0, 5'd4, 1, 0, 1, 0, 0);
        chk("mis_nreq", r_nreq, 0);
        chk("mis_lat", r_lat, 2);
        chk("mis_exc", {r_wren, r_exc, r_code}, {1'b0, 1'b1, 2'b01});

        // timeout: no ack
        run_op(1, 0, 3'b010, 32'h0100, 0, 5'd6, 1, 0, 0, 0, 0);
        chk("to_nreq", r_nreq, TIMEOUT);
        chk("to_lat", r_lat, TIMEOUT + 2);
        chk("to_exc", {r_wren, r_exc, r_code}, {1'b0, 1'b1, 2'b11});

        // ack in the same cycle the timeout would fire
        run_op(1, 0, 3'b010, 32'h0104, 0, 5'd9, 1, 0, TIMEOUT, 0, 32'hDEAD_BEEF);
        chk("ackto_exc", {r_wren, r_exc}, 2'b10);
        chk("ackto_data", r_data, 32'hDEAD_BEEF);

        // LBU to x0 with bus error, then without
        run_op(1, 0, 3'b100, 32'h0011, 0, 5'd0, 1, 0, 1, 1, 32'h0000_F000);
        chk("err_exc", {r_wren, r_exc, r_code}, {1'b0, 1'b1, 2'b10});
        run_op(1, 0, 3'b100, 32'h0011, 0, 5'd0, 1, 0, 1, 0, 32'h0000_F000);
        chk("x0_exc_wren", {r_wren, r_exc}, 2'b00);
        chk("x0_data", r_data, 32'h0000_00F0);

        // non-memory ops
        run_op(0, 0, 3'b000, 0, 0, 5'd7, 1, 32'h5A5A_1234, 1, 0, 0);
        chk("alu_lat_nreq", {r_lat[7:0], r_nreq[7:0]}, {8'd2, 8'd0});
        chk("alu_data", r_data, 32'h5A5A_1234);
        chk("alu_wren", {r_wren, r_exc}, 2'b10);
        run_op(0, 0, 3'b000, 0, 0, 5'd0, 1, 32'h0000_0001, 1, 0, 0);
        chk("alu_x0_wren", r_wren, 1'b0);

        // LD illegal on 32-bit data path
        run_op(1, 0, 3'b011, 32'h0008, 0, 5'd2, 1, 0, 1, 0, 0);
        chk("ld_illegal", {r_nreq[3:0], r_exc, r_code}, {4'd0, 1'b1, 2'b01});

        // LH / LHU upper half
        run_op(1, 0, 3'b001, 32'h3002, 0, 5'd8, 1, 0, 1, 0, 32'h8765_4321);
        chk("lh_data", r_data, 32'hFFFF_8765);
        run_op(1, 0, 3'b101, 32'h3002, 0, 5'd8, 1, 0, 1, 0, 32'h8765_4321);
        chk("lhu_data", r_data, 32'h0000_8765);

        // load+store both set acts as SB; then SW
        run_op(1, 1, 3'b000, 32'h4001, 32'h0000_00AB, 5'd1, 1, 0, 1, 0, 0);
        chk("sb_be", {r_we, r_be}, 5'b1_0010);
        chk("sb_wdata", r_wdata, 32'h0000_AB00);
        chk("sb_wren", r_wren, 1'b0);
        run_op(0, 1, 3'b010, 32'h4000, 32'hCAFE_F00D, 5'd1, 0, 0, 2, 0, 0);
        chk("sw_be", {r_we, r_be}, 5'b1_1111);
        chk("sw_wdata", r_wdata, 32'hCAFE_F00D);
        chk("sw_stable", r_stable, 1'b1);

        // reset in the middle of a bus transfer
        @(negedge clk);
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
        in_addr = 32'h0500; in_rd_addr = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_req_up", bus_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_req_drop", bus_req, 1'b0);
        chk("mid_ready", in_ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_valid0", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("late_ack_valid1", out_valid, 1'b0);
        chk("after_rst_ready", in_ready, 1'b1);

        run_op(0, 0, 3'b000, 0, 0, 5'd12, 1, 32'h0BAD_CAFE, 1, 0, 0);
        chk("recover_data", {r_lat[7:0], r_data}, {8'd2, 32'h0BAD_CAFE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter DATA_W, default 32, SHALL be the data path width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL be the byte address width.
REQ-003 Parameter TIMEOUT, default 16, SHALL be the maximum number of bus_req cycles without bus_ack; legal range is 2..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Ports, listed as name, direction, width, meaning:
 clk  in  1  clock, rising edge.
 rst  in  1  asynchronous active-high reset.
 in_valid  in  1  ex stage operation valid.
 in_ready  out  1  block can accept an operation.
 in_is_load, in_is_store  in  1 each  operation class.
 in_funct3  in  3  RISC-V load/store funct3.
 in_addr  in  ADDR_W  effective byte address.
 in_wdata  in  DATA_W  store data (rs2).
 in_rd_addr  in  5  destination register.
 in_rd_wr_en  in  1  register write request from ex.
 in_rd_data  in  DATA_W  ex result for non-memory operations.
 bus_req  out  1  memory request.
 bus_we  out  1  write strobe.
 bus_addr  out  ADDR_W  word-aligned address.
 bus_be  out  DATA_W/8  byte enables.
 bus_wdata  out  DATA_W  lane-shifted store data.
 bus_ack  in  1  request completed.
 bus_err  in  1  error, valid with bus_ack.
 bus_rdata  in  DATA_W  read data, valid with bus_ack.
 out_valid  out  1  one-cycle result pulse to wb.
 out_rd_wr_en  out  1  register write enable.
 out_rd_addr  out  5  destination register.
 out_rd_data  out  DATA_W  write-back data.
 out_exc  out  1  exception flag.
 out_exc_code  out  2  01 = misaligned, 10 = bus error, 11 = timeout.

Function
REQ-006 The FSM SHALL have three states: IDLE, BUS and DONE; in_ready SHALL be 1 only in IDLE.
REQ-007 An operation SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; all operation inputs SHALL be captured into internal registers on that edge.
REQ-008 A non-memory operation (in_is_load=0, in_is_store=0) SHALL go IDLE->DONE and produce out_valid on the next cycle with out_rd_data=in_rd_data and out_rd_wr_en=in_rd_wr_en.
REQ-009 When in_is_load=1 and in_is_store=1 are both set, the operation SHALL be treated as a store.
REQ-010 Alignment rule: halfword SHALL require addr[0]=0, word SHALL require addr[1:0]=0, doubleword SHALL require addr[2:0]=0; a violation SHALL go IDLE->DONE with no bus_req, out_exc=1, out_exc_code=01 and out_rd_wr_en=0.
REQ-011 An aligned memory operation SHALL go IDLE->BUS.
REQ-012 bus_req SHALL be 1 throughout BUS, and bus_addr, bus_we, bus_be and bus_wdata SHALL be held stable while bus_req=1.
REQ-013 bus_addr SHALL equal the captured address with its low log2(DATA_W/8) bits cleared.
REQ-014 Store byte enables: SB SHALL set one bus_be bit at the lane offset, SH two bits, SW four bits, SD (DATA_W=64 only) all bits; bus_wdata SHALL be rs2 shifted left by 8*offset.
REQ-015 Stores SHALL NOT perform a read-modify-write.
REQ-016 Loads SHALL drive bus_we=0 and bus_be=0.
REQ-017 On load completion, the loaded data SHALL be bus_rdata shifted right by 8*offset, then extended as follows:
 LB, LH, LW: sign-extended.
 LBU, LHU, LWU: zero-extended.
 LD: full width.
 LWU and LD exist only when DATA_W=64; for DATA_W=32, funct3 values 011 and 110 are illegal.
REQ-018 An illegal funct3 SHALL be treated as a misaligned access (code 01).
REQ-019 bus_ack=1 in BUS SHALL move the FSM to DONE.
REQ-020 If bus_err=0 at ack: a load SHALL produce out_rd_wr_en=1 unless rd=0, and a store SHALL produce out_rd_wr_en=0.
REQ-021 If bus_err=1 at ack, the block SHALL produce out_exc=1, out_exc_code=10 and out_rd_wr_en=0.
REQ-022 A wait counter SHALL count BUS cycles; if it reaches TIMEOUT with bus_ack=0, bus_req SHALL drop, the FSM SHALL go to DONE, and the result SHALL be out_exc=1, out_exc_code=11, out_rd_wr_en=0.
REQ-023 When bus_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL take priority.
REQ-024 DONE SHALL last exactly one cycle with out_valid=1, then return to IDLE; the earliest new acceptance SHALL be the cycle after DONE.
REQ-025 out_rd_wr_en SHALL be 0 whenever out_rd_addr=0.
REQ-026 All out_* signals SHALL be registered, and out_rd_data SHALL hold its value outside DONE.
REQ-027 Memory operation latency SHALL be 1 (accept) + N (bus wait, ack in cycle N) + 1 (DONE) cycles.

Reset
REQ-028 While rst=1, the FSM SHALL be forced to IDLE, the wait counter cleared, and every output and internal register driven to 0, except in_ready=1.
REQ-029 Reset asserted in BUS SHALL drop bus_req immediately (asynchronously); a bus_ack received after reset release SHALL be ignored in IDLE.

Verification
REQ-030 Load byte (DATA_W=32): LB at addr 0x1003 with bus_rdata=0x80FF_FFFF, ack after 2 cycles -> out_rd_data=0xFFFF_FF80, out_valid exactly 4 cycles after acceptance.
REQ-031 Store halfword: SH at addr 0x2002 with rs2=0x1234_ABCD -> bus_be=1100, bus_wdata=0xABCD_0000, bus_addr=0x2000, out_rd_wr_en=0.
REQ-032 Misaligned access: LW at addr 0x0006 -> no bus_req, next cycle out_exc=1 with code 01 and out_rd_wr_en=0.
REQ-033 Timeout: TIMEOUT=4 with bus_ack held at 0 -> bus_req high exactly 4 cycles, then out_exc=1 with code 11.
REQ-034 Bus error and x0: LBU to rd=0 with bus_err=1 at ack -> out_exc code 10 and out_rd_wr_en=0; the same operation without error -> out_rd_wr_en=0 because rd=0.
REQ-035 Reset mid-operation: rst pulsed during BUS -> bus_req=0 immediately; a late ack produces no out_valid; in_ready=1 after release.
